// File: rtl/emd_extrema_sched.sv
// emd_extrema_sched: sequencer for the EMD extrema-detection stage.
// Streams a frame of signed samples through a 3-sample window (a, b, c).
// The middle sample b is classified as a local minimum or maximum.
// Extrema and the two frame-boundary points are queued in a show-ahead FIFO.
// The downstream envelope-interpolation stage pops that FIFO over valid/ready.
module emd_extrema_sched #(
  parameter int DW    = 16,
  parameter int IW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] len,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic          ext_vld,
  input  logic          ext_rdy,
  output logic [1:0]    ext_type,
  output logic [IW-1:0] ext_idx,
  output logic [DW-1:0] ext_val,
  output logic [IW-1:0] min_cnt,
  output logic [IW-1:0] max_cnt,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 + IW + DW;

  localparam logic [1:0] TYPE_MIN      = 2'b01;
  localparam logic [1:0] TYPE_MAX      = 2'b10;
  localparam logic [1:0] TYPE_BOUNDARY = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]        len_q;
  logic [IW-1:0]        idx_q;
  logic signed [DW-1:0] win_a;
  logic signed [DW-1:0] win_b;
  logic signed [DW-1:0] din_s;
  logic [IW-1:0]        min_q;
  logic [IW-1:0]        max_q;
  logic                 din_rdy_q;
  logic                 din_rdy_nxt;

  logic [EW-1:0]        mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic [EW-1:0]        head;

  logic                 accept;
  logic                 pop;
  logic                 is_min;
  logic                 is_max;
  logic                 wr_en;
  logic [1:0]           wr_type;
  logic [IW-1:0]        wr_idx;
  logic [DW-1:0]        wr_val;

  assign din_s   = $signed(din);
  assign accept  = (state == RUN) && din_vld && din_rdy_q;
  assign ext_vld = (count != '0);
  assign pop     = ext_vld && ext_rdy;

  // The window is only full once two earlier samples exist; comparisons are strict and signed
  assign is_min = (idx_q >= IW'(2)) && (win_b < win_a) && (win_b < din_s);
  assign is_max = (idx_q >= IW'(2)) && (win_b > win_a) && (win_b > din_s);

  // Choose the single FIFO write of this cycle: first boundary, an extremum, or the closing boundary
  always_comb begin
    wr_en   = 1'b0;
    wr_type = '0;
    wr_idx  = '0;
    wr_val  = '0;
    if (accept) begin
      if (idx_q == '0) begin
        wr_en   = 1'b1;
        wr_type = TYPE_BOUNDARY;
        wr_idx  = '0;
        wr_val  = din;
      end else if (is_min) begin
        wr_en   = 1'b1;
        wr_type = TYPE_MIN;
        wr_idx  = idx_q - IW'(1);
        wr_val  = win_b;
      end else if (is_max) begin
        wr_en   = 1'b1;
        wr_type = TYPE_MAX;
        wr_idx  = idx_q - IW'(1);
        wr_val  = win_b;
      end
    end else if (state == TAIL) begin
      wr_en   = 1'b1;
      wr_type = TYPE_BOUNDARY;
      wr_idx  = len_q - IW'(1);
      wr_val  = win_b;
    end
  end

  // Next-state logic; din_rdy is precomputed here so it can be registered without a DIN_VLD/EXT_RDY path
  always_comb begin
    state_nxt = state;
    count_nxt = count + CW'(wr_en) - CW'(pop);
    case (state)
      IDLE:    if (start && (len >= IW'(3))) state_nxt = RUN;
      RUN:     if (accept && (idx_q == len_q - IW'(1))) state_nxt = TAIL;
      TAIL:    state_nxt = DRAIN;
      DRAIN:   if (count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    din_rdy_nxt = (state_nxt == RUN) && (count_nxt <= CW'(DEPTH - 2));
  end

  // Frame control: state, latched length, sample index, window and extremum counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      din_rdy_q <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      win_a     <= '0;
      win_b     <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      state     <= state_nxt;
      din_rdy_q <= din_rdy_nxt;
      if ((state == IDLE) && (state_nxt == RUN)) begin
        len_q <= len;
        idx_q <= '0;
        win_a <= '0;
        win_b <= '0;
        min_q <= '0;
        max_q <= '0;
      end
      if (accept) begin
        idx_q <= idx_q + IW'(1);
        win_a <= win_b;
        win_b <= din_s;
        if (is_min) min_q <= min_q + IW'(1);
        if (is_max) max_q <= max_q + IW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents need no reset because the outputs are masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_type, wr_idx, wr_val};
  end

  assign head = mem[rd_ptr];
  assign {ext_type, ext_idx, ext_val} = ext_vld ? head : '0;

  assign din_rdy = din_rdy_q;
  assign min_cnt = min_q;
  assign max_cnt = max_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DRAIN) && (count == '0);

endmodule

// File: tb/tb_emd_extrema_sched.sv
// tb_emd_extrema_sched: directed and random frames for emd_extrema_sched.
// A frame-level reference model predicts the entry sequence and the counts.
// A monitor checks every popped entry against that prediction.
module tb_emd_extrema_sched;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [15:0]         len = '0;
  logic [15:0]         din = '0;
  logic                din_vld = 1'b0;
  logic                din_rdy;
  logic                ext_vld;
  logic                ext_rdy = 1'b1;
  logic [1:0]          ext_type;
  logic [15:0]         ext_idx;
  logic [15:0]         ext_val;
  logic [15:0]         min_cnt;
  logic [15:0]         max_cnt;
  logic                busy;
  logic                done;

  int                  compare_count = 0;
  int                  fail_count = 0;
  int                  done_count = 0;
  int                  rdy_mode = 0;
  logic signed [15:0]  frame_q[$];
  logic [33:0]         exp_q[$];
  int                  exp_min;
  int                  exp_max;
  logic [33:0]         mon_exp;

  emd_extrema_sched #(.DW(16), .IW(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .ext_vld(ext_vld), .ext_rdy(ext_rdy), .ext_type(ext_type),
    .ext_idx(ext_idx), .ext_val(ext_val),
    .min_cnt(min_cnt), .max_cnt(max_cnt), .busy(busy), .done(done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Downstream ready: 0 = always ready, 1 = held off, 2 = random gaps
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ext_rdy = 1'b1;
      1:       ext_rdy = 1'b0;
      default: ext_rdy = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    compare_count++;
    fail_count++;
    $display("[TB] FAIL %s: bound expired, got no event, expected event", name);
  endtask

  // Reference: boundary points at both ends plus every strict signed interior extremum
  function automatic void buildModel();
    int n;
    n = frame_q.size();
    exp_q.delete();
    exp_min = 0;
    exp_max = 0;
    exp_q.push_back({2'b11, 16'd0, frame_q[0]});
    for (int i = 1; i < n - 1; i++) begin
      if (frame_q[i] < frame_q[i-1] && frame_q[i] < frame_q[i+1]) begin
        exp_q.push_back({2'b01, 16'(i), frame_q[i]});
        exp_min++;
      end else if (frame_q[i] > frame_q[i-1] && frame_q[i] > frame_q[i+1]) begin
        exp_q.push_back({2'b10, 16'(i), frame_q[i]});
        exp_max++;
      end
    end
    exp_q.push_back({2'b11, 16'(n - 1), frame_q[n-1]});
  endfunction

  // Every pop is compared against the head of the predicted sequence; DONE must coincide with an empty FIFO
  always @(negedge clk) begin
    if (!rst && ext_vld && ext_rdy) begin
      if (exp_q.size() == 0) begin
        compare_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_entry: got %0h, expected none", {ext_type, ext_idx, ext_val});
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("ext_entry", {ext_type, ext_idx, ext_val}, mon_exp);
      end
    end
    if (!rst && done) begin
      done_count++;
      checkOutput("done_fifo_empty", ext_vld, 0);
    end
  end

  // Runs the frame in frame_q; the model must already be built
  task automatic applyStimulus(input int n, input int gap_max, input bit hold_rdy, input int mid_start_after);
    int cyc;
    int done_before;
    done_before = done_count;
    if (hold_rdy) rdy_mode = 1;
    @(posedge clk); #1;
    start = 1'b1;
    len = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("din_rdy_after_start", din_rdy, 1);
    if (hold_rdy) begin
      fork
        begin
          repeat (40) @(negedge clk);
          checkOutput("stall_din_rdy", din_rdy, 0);
          checkOutput("stall_ext_vld", ext_vld, 1);
          rdy_mode = 0;
        end
      join_none
    end
    for (int k = 0; k < n; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      din = frame_q[k];
      din_vld = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!din_rdy && cyc < 200);
      if (!din_rdy) begin
        reportFail("din_accept_timeout");
        din_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
      din_vld = 1'b0;
      if (k == mid_start_after) begin
        start = 1'b1;
        len = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        len = 16'(n);
        checkOutput("busy_after_mid_start", busy, 1);
      end
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 2000);
    if (!done) begin
      reportFail("done_timeout");
      return;
    end
    repeat (4) @(negedge clk);
    checkOutput("done_pulses", done_count - done_before, 1);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("entries_left", exp_q.size(), 0);
    checkOutput("min_cnt", min_cnt, exp_min);
    checkOutput("max_cnt", max_cnt, exp_max);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_din_rdy"}, din_rdy, 0);
    checkOutput({tag, "_ext_vld"}, ext_vld, 0);
    checkOutput({tag, "_ext_type"}, ext_type, 0);
    checkOutput({tag, "_ext_idx"}, ext_idx, 0);
    checkOutput({tag, "_ext_val"}, ext_val, 0);
    checkOutput({tag, "_min_cnt"}, min_cnt, 0);
    checkOutput({tag, "_max_cnt"}, max_cnt, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Directed test sequence
  initial begin
    int done_before;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues("reset");

    // Classic 3,1,4,1,5 frame with an always-ready consumer
    frame_q = '{16'sd3, 16'sd1, 16'sd4, 16'sd1, 16'sd5};
    buildModel();
    checkOutput("model1_size", exp_q.size(), 5);
    checkOutput("model1_e1", exp_q[1], {2'b01, 16'd1, 16'd1});
    checkOutput("model1_e2", exp_q[2], {2'b10, 16'd2, 16'd4});
    checkOutput("model1_e4", exp_q[4], {2'b11, 16'd4, 16'd5});
    checkOutput("model1_min", exp_min, 2);
    checkOutput("model1_max", exp_max, 1);
    applyStimulus(5, 0, 1'b0, -1);

    // Negative samples need a signed compare
    frame_q = '{-16'sd5, -16'sd10, -16'sd3};
    buildModel();
    checkOutput("model2_e1", exp_q[1], {2'b01, 16'd1, 16'hfff6});
    checkOutput("model2_e2", exp_q[2], {2'b11, 16'd2, 16'hfffd});
    applyStimulus(3, 0, 1'b0, -1);

    // Plateau gives only the boundary entries
    frame_q = '{16'sd2, 16'sd2, 16'sd2, 16'sd2};
    buildModel();
    checkOutput("model3_size", exp_q.size(), 2);
    applyStimulus(4, 0, 1'b0, -1);

    // Alternating frame against a held-off consumer, then released
    frame_q = '{16'sd0, 16'sd9, 16'sd0, 16'sd9, 16'sd0, 16'sd9, 16'sd0, 16'sd9};
    buildModel();
    checkOutput("model4_min", exp_min, 3);
    checkOutput("model4_max", exp_max, 3);
    applyStimulus(8, 0, 1'b1, -1);

    // Longer alternating frame that must stall on a nearly full FIFO
    frame_q = '{16'sd0, 16'sd9, 16'sd0, 16'sd9, 16'sd0, 16'sd9,
                16'sd0, 16'sd9, 16'sd0, 16'sd9, 16'sd0, 16'sd9};
    buildModel();
    applyStimulus(12, 0, 1'b1, -1);

    // Too-short frame request is ignored, even with samples offered
    @(posedge clk); #1;
    start = 1'b1;
    len = 16'd2;
    din_vld = 1'b1;
    din = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("short_busy", busy, 0);
    checkOutput("short_din_rdy", din_rdy, 0);
    repeat (3) begin @(posedge clk); #1; end
    din_vld = 1'b0;
    checkOutput("short_ext_vld", ext_vld, 0);
    checkOutput("short_busy_later", busy, 0);

    // Second START during RUN must not shorten the frame
    frame_q = '{16'sd1, 16'sd8, -16'sd2, 16'sd6, 16'sd6};
    buildModel();
    applyStimulus(5, 0, 1'b0, 1);

    // Reset in the middle of a frame abandons it without DONE
    rdy_mode = 1;
    done_before = done_count;
    @(posedge clk); #1;
    start = 1'b1;
    len = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (frame_q[i]) begin end
    din = 16'sd5; din_vld = 1'b1; @(posedge clk); #1;
    din = 16'sd1; @(posedge clk); #1;
    din = 16'sd7; @(posedge clk); #1;
    din_vld = 1'b0;
    checkOutput("pre_reset_min_cnt", min_cnt, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetValues("midreset");
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_done", done_count - done_before, 0);
    rdy_mode = 0;
    @(posedge clk); #1;

    frame_q = '{16'sd4, -16'sd4, 16'sd4, -16'sd4, 16'sd3, 16'sd3, 16'sd2, 16'sd5, 16'sd1, 16'sd0};
    buildModel();
    applyStimulus(10, 0, 1'b0, -1);

    // Random 64-sample frame with input gaps and a random consumer
    frame_q.delete();
    for (int i = 0; i < 64; i++) frame_q.push_back(16'($signed($urandom_range(0, 20)) - 10));
    buildModel();
    rdy_mode = 2;
    applyStimulus(64, 3, 1'b0, -1);
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    fail_count++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/emd_extrema_sched.md
# emd_extrema_sched

Sequencer for the EMD extrema-detection stage. It accepts a frame of signed samples as a stream and maintains the sample-index counter. It runs a 3-sample sliding window (A = x[k-2], B = x[k-1], C = x[k]) and classifies B as a local minimum or maximum. Detected extrema, plus the two frame-boundary points, are queued in an internal FIFO for the downstream envelope-interpolation stage over a valid/ready handshake.

## Interface
- DW, 16, sample width (signed two's complement)
- IW, 16, index/length width
- DEPTH, 8, extremum FIFO depth (power of 2, ≥4)

- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle frame start request
- LEN  in  IW  frame length in samples, sampled with START
- DIN  in  DW  signed sample
- DIN_VLD  in  1  sample valid
- DIN_RDY  out  1  sample accepted when DIN_VLD & DIN_RDY
- EXT_VLD  out  1  FIFO head valid
- EXT_RDY  in  1  downstream pops head when EXT_VLD & EXT_RDY
- EXT_TYPE  out  2  01 = min, 10 = max, 11 = boundary
- EXT_IDX  out  IW  sample index of extremum
- EXT_VAL  out  DW  sample value of extremum
- MIN_CNT  out  IW  interior minima found in current/last frame
- MAX_CNT  out  IW  interior maxima found in current/last frame
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, RUN, TAIL, DRAIN.
- IDLE:
  - START with LEN ≥ 3 latches LEN, clears the index counter, MIN_CNT, MAX_CNT and window, then goes to RUN.
  - START with LEN < 3 is ignored; the block stays in IDLE with BUSY low.
- START outside IDLE is ignored.
- RUN:
  - DIN_RDY = 1 when FIFO free entries ≥ 2; otherwise 0. No entry is ever dropped.
  - Each accepted sample gets index k = 0, 1, … in order and shifts into the window.
  - k = 0: write {11, 0, x[0]}.
  - k ≥ 2, B = x[k-1]:
    - B < A and B < C: write {01, k-1, B} and increment MIN_CNT.
    - B > A and B > C: write {10, k-1, B} and increment MAX_CNT.
    - Otherwise no write.
  - Comparisons are signed and strict. Plateaus and equal neighbours produce no extremum.
  - Acceptance of k = LEN-1 (after its window evaluation) goes to TAIL with DIN_RDY = 0.
- TAIL: write {11, LEN-1, x[LEN-1]} (space is guaranteed by the ≥2 rule), then go to DRAIN.
- DRAIN: DIN_RDY = 0. When the FIFO is empty, pulse DONE, drop BUSY and go to IDLE.
- At most one FIFO write per cycle. FIFO is show-ahead: EXT_* show the head whenever EXT_VLD = 1.
- A write and a pop in the same cycle are both performed; occupancy is unchanged.
- MIN_CNT/MAX_CNT hold their value after DONE until the next accepted START.
- RST in any state:
  - Return to IDLE and empty the FIFO.
  - Clear the counters, window and BUSY.
  - The in-flight frame is abandoned; no DONE pulse is issued.

## Timing
- Reset values: DIN_RDY = 0, EXT_VLD = 0, EXT_TYPE = 0, EXT_IDX = 0, EXT_VAL = 0, MIN_CNT = 0, MAX_CNT = 0, BUSY = 0, DONE = 0.
- START accepted at edge t: BUSY = 1 and DIN_RDY = 1 from cycle t+1.
- Sample k accepted at edge t: the resulting entry (boundary for k = 0, extremum for B = x[k-1] for k ≥ 2) is in the FIFO, with EXT_VLD = 1 in cycle t+1 if the FIFO was empty.
- The counter update is visible in the same cycle as that entry.
- Last sample accepted at edge t: TAIL during cycle t+1; boundary entry written at edge t+1.
- DONE is asserted in the cycle after the last pop, with the FIFO empty.
- DIN_RDY is a registered function of occupancy and state; it never depends combinationally on DIN_VLD or EXT_RDY.
- EXT_* must stay stable while EXT_VLD = 1 and EXT_RDY = 0.
- Index counter: IW bits; a frame never exceeds LEN, so it never wraps.

## Test plan
- LEN = 5, samples 3, 1, 4, 1, 5, EXT_RDY = 1 -> entries {11,0,3}, {01,1,1}, {10,2,4}, {01,3,1}, {11,4,5}; MIN_CNT = 2, MAX_CNT = 1; exactly one DONE pulse.
- LEN = 3, samples -5, -10, -3 -> {11,0,-5}, {01,1,-10}, {11,2,-3}, confirming signed compare; LEN = 4, samples 2, 2, 2, 2 -> only the two boundary entries, counts 0/0.
- LEN = 8 alternating 0, 9, 0, 9, …, EXT_RDY = 0 -> DIN_RDY falls once the FIFO holds DEPTH-1 entries; releasing EXT_RDY gives an ordered, lossless output with MIN_CNT = 3, MAX_CNT = 3.
- START with LEN = 2 -> BUSY stays 0, DIN_RDY stays 0, no entries; a second START during RUN is ignored and LEN is unchanged.
- RST asserted after 3 samples of a LEN = 10 frame -> next cycle all outputs at reset values, no DONE; a new frame then runs correctly from index 0.
- Random DIN_VLD/EXT_RDY gaps on a 64-sample random frame -> output sequence matches a reference model.
